// File: rtl/fetch_seq_pkg.sv
// Shared constants, state encoding and helpers for the fetch sequencer.
// Phase numbers name the cycle in which each sequencer action happens.
package fetch_seq_pkg;

  localparam int ADDR_W_DEFAULT = 12;

  localparam logic [2:0] CYCLE_LATCH = 3'd0;
  localparam logic [2:0] CYCLE_JUMP  = 3'd3;
  localparam logic [2:0] CYCLE_FETCH = 3'd4;
  localparam logic [2:0] CYCLE_LAST  = 3'd4;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Next phase value; anything at or past the last phase returns to the latch phase.
  function automatic logic [2:0] cycle_next(input logic [2:0] c);
    return (c >= CYCLE_LAST) ? CYCLE_LATCH : (c + 3'd1);
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// ROM-side bus of the fetch sequencer: phase and address out, read data in.
interface fetch_seq_if
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic [2:0]        cycle;
  logic [ADDR_W-1:0] address;
  logic [7:0]        rom_data;

  modport master (output cycle, output address, input rom_data);
  modport slave  (input cycle, input address, output rom_data);

endinterface

// File: rtl/fetch_seq_cycle_gen.sv
// Five-phase counter 0..4; hold freezes the current phase (used while halting).
module cycle_gen
  import fetch_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  output logic [2:0] cycle
);

  logic [2:0] cycle_q;
  logic [2:0] cycle_d;

  // Next phase: hold or advance with wrap after the last phase.
  always_comb begin
    cycle_d = cycle_q;
    if (hold) begin
      cycle_d = cycle_q;
    end else begin
      cycle_d = cycle_next(cycle_q);
    end
  end

  // Phase register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q <= CYCLE_LATCH;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle = cycle_q;

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: drives PC and phase to the ROM, latches the
// fetched byte, supports a phase-3 jump and halting at instruction boundaries.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
)(
  input  logic              clk,
  input  logic              rst_n,
  fetch_seq_if.master       rom,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic [7:0]        instr,
  output logic              instr_valid,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fetched_q, fetched_d;
  logic              hold_s;
  logic [2:0]        cycle_s;

  cycle_gen u_cycle_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold_s),
    .cycle (cycle_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: halt is only honoured at the latch phase boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt && (cycle_s == CYCLE_LATCH)) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (!halt) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Datapath next values; fetched_q guards the latch until a ROM read has happened.
  always_comb begin
    addr_d    = addr_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    fetched_d = fetched_q;
    hold_s    = 1'b0;
    if (halt && (cycle_s == CYCLE_LATCH)) begin
      hold_s = 1'b1;
    end else begin
      hold_s = 1'b0;
    end
    if (state_q == ST_RUN) begin
      case (cycle_s)
        CYCLE_LATCH: begin
          if (fetched_q) begin
            instr_d = rom.rom_data;
            valid_d = 1'b1;
          end else begin
            instr_d = instr_q;
            valid_d = valid_q;
          end
        end
        CYCLE_JUMP: begin
          if (jump_en) begin
            addr_d = jump_addr;
          end else begin
            addr_d = addr_q;
          end
        end
        CYCLE_FETCH: begin
          addr_d    = addr_q + ADDR_W'(1);
          fetched_d = 1'b1;
        end
        default: addr_d = addr_q;
      endcase
    end else begin
      addr_d = addr_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= RESET_PC;
      instr_q   <= 8'h00;
      valid_q   <= 1'b0;
      fetched_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      fetched_q <= fetched_d;
    end
  end

  assign rom.cycle   = cycle_s;
  assign rom.address = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: a ROM model feeds the DUT and a queue of
// ROM bytes read at phase 4 is compared against instr at the following phase 1.
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          jump_en = 1'b0;
  logic [AW-1:0] jump_addr = 12'h000;
  logic          halt = 1'b0;
  logic [7:0]    instr;
  logic          instr_valid;
  logic          halted;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  logic [7:0] mem [0:4095];
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  fetch_seq_if #(.ADDR_W(AW)) rom_if ();

  fetch_seq #(.ADDR_W(AW), .RESET_PC(12'h000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom         (rom_if),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .instr       (instr),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // ROM model: samples the address on the phase-4 edge.
  always @(posedge clk) begin
    if (rom_if.cycle == 3'd4) rom_if.rom_data <= mem[rom_if.address];
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      n_cmp++;
      if (rom_if.cycle > 3'd4) begin
        n_fail++;
        $display("FAIL cycle_range: got %0d, need 0..4", rom_if.cycle);
      end
      if (rom_if.cycle == 3'd1 && exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        n_cmp++;
        if (instr !== exp_b || instr_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL sb_instr: got %h/v%b, need %h/v1", instr, instr_valid, exp_b);
        end
      end
      if (rom_if.cycle == 3'd4) exp_q.push_back(mem[rom_if.address]);
    end
  end

  task automatic wait_cycle(input logic [2:0] c);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (rom_if.cycle == c) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_cycle: phase %0d not reached, cycle=%0d", c, rom_if.cycle);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rom_if.cycle !== 3'd0 || rom_if.address !== 12'h000 || instr !== 8'h00 ||
        instr_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got c%0d a%h i%h v%b h%b, need c0 a000 i00 v0 h0",
               rom_if.cycle, rom_if.address, instr, instr_valid, halted);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_sequence;
    wait_cycle(3'd1);
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_round_valid: got %b, need 0", instr_valid);
    end
    for (int k = 0; k < 4; k++) begin
      wait_cycle(3'd4);
      n_cmp++;
      if (rom_if.address !== AW'(k)) begin
        n_fail++;
        $display("FAIL seq_addr: got %h, need %h", rom_if.address, AW'(k));
      end
    end
  endtask

  task automatic test_jump_ignored;
    logic [AW-1:0] pc;
    wait_cycle(3'd2);
    pc = rom_if.address;
    jump_en = 1'b1;
    jump_addr = 12'h777;
    @(negedge clk);
    jump_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rom_if.address !== pc) begin
      n_fail++;
      $display("FAIL jump_at_c2: got %h, need %h", rom_if.address, pc);
    end
  endtask

  task automatic test_jump;
    wait_cycle(3'd3);
    jump_en = 1'b1;
    jump_addr = 12'h123;
    @(negedge clk);
    jump_en = 1'b0;
    n_cmp++;
    if (rom_if.cycle !== 3'd4 || rom_if.address !== 12'h123) begin
      n_fail++;
      $display("FAIL jump_addr: got c%0d a%h, need c4 a123", rom_if.cycle, rom_if.address);
    end
    wait_cycle(3'd1);
    n_cmp++;
    if (instr !== 8'h5C) begin
      n_fail++;
      $display("FAIL jump_instr: got %h, need 5c", instr);
    end
  endtask

  task automatic test_wrap;
    wait_cycle(3'd3);
    jump_en = 1'b1;
    jump_addr = 12'hFFF;
    @(negedge clk);
    jump_en = 1'b0;
    n_cmp++;
    if (rom_if.address !== 12'hFFF) begin
      n_fail++;
      $display("FAIL wrap_fff: got %h, need fff", rom_if.address);
    end
    wait_cycle(3'd1);
    n_cmp++;
    if (instr !== 8'hE7) begin
      n_fail++;
      $display("FAIL wrap_instr_fff: got %h, need e7", instr);
    end
    wait_cycle(3'd4);
    n_cmp++;
    if (rom_if.address !== 12'h000) begin
      n_fail++;
      $display("FAIL wrap_000: got %h, need 000", rom_if.address);
    end
    wait_cycle(3'd1);
    n_cmp++;
    if (instr !== 8'hA1) begin
      n_fail++;
      $display("FAIL wrap_instr_000: got %h, need a1", instr);
    end
  endtask

  task automatic test_halt;
    logic [AW-1:0] pc_pre;
    wait_cycle(3'd2);
    halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pc_pre = rom_if.address;
    n_cmp++;
    if (rom_if.cycle !== 3'd4 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_early: got c%0d h%b, need c4 h0", rom_if.cycle, halted);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (halted !== 1'b1 || instr !== mem[pc_pre] || instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_latch: got h%b i%h v%b, need h1 i%h v1",
               halted, instr, instr_valid, mem[pc_pre]);
    end
    jump_en = 1'b1;
    jump_addr = 12'h555;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (halted !== 1'b1 || rom_if.cycle !== 3'd0 || rom_if.address !== pc_pre + 12'h001) begin
        n_fail++;
        $display("FAIL halt_hold: got h%b c%0d a%h, need h1 c0 a%h",
                 halted, rom_if.cycle, rom_if.address, pc_pre + 12'h001);
      end
    end
    jump_en = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (halted !== 1'b0 || rom_if.cycle !== 3'd1) begin
      n_fail++;
      $display("FAIL halt_resume: got h%b c%0d, need h0 c1", halted, rom_if.cycle);
    end
    wait_cycle(3'd4);
    n_cmp++;
    if (rom_if.address !== pc_pre + 12'h001) begin
      n_fail++;
      $display("FAIL halt_next_addr: got %h, need %h", rom_if.address, pc_pre + 12'h001);
    end
  endtask

  task automatic test_reset_mid;
    wait_cycle(3'd3);
    jump_en = 1'b1;
    jump_addr = 12'h03F;
    @(negedge clk);
    jump_en = 1'b0;
    wait_cycle(3'd3);
    n_cmp++;
    if (rom_if.address !== 12'h040) begin
      n_fail++;
      $display("FAIL mid_pc: got %h, need 040", rom_if.address);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rom_if.cycle !== 3'd0 || rom_if.address !== 12'h000 || instr_valid !== 1'b0 ||
        instr !== 8'h00 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got c%0d a%h v%b i%h h%b, need c0 a000 v0 i00 h0",
               rom_if.cycle, rom_if.address, instr_valid, instr, halted);
    end
    exp_q.delete();
    rst_n = 1'b1;
    wait_cycle(3'd1);
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_discard: got v%b, need v0", instr_valid);
    end
    wait_cycle(3'd1);
    n_cmp++;
    if (instr !== 8'hA1 || instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_first_instr: got %h/v%b, need a1/v1", instr, instr_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 7) + 3) ^ 8'(i >> 4);
    mem[0]      = 8'hA1;
    mem[1]      = 8'hA2;
    mem[2]      = 8'hA3;
    mem[12'h123] = 8'h5C;
    mem[12'hFFF] = 8'hE7;

    test_reset();
    test_sequence();
    test_jump_ignored();
    test_jump();
    test_wrap();
    test_halt();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
